// File: rtl/l2_mem_pkg.sv
// Shared types and constants for the L2 backing-memory responder.
package l2_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int unsigned WORD_WIDTH              = 32;
  localparam int unsigned WSTRB_WIDTH             = 4;
  localparam int unsigned CNT_WIDTH               = 8;
  localparam int unsigned DEFAULT_OFFSET_WIDTH    = 2;
  localparam int unsigned DEFAULT_MEM_INDEX_WIDTH = 10;
  localparam int unsigned DEFAULT_LATENCY         = 4;

  // Line width in bits for 2**offset_width words per line.
  function automatic int unsigned line_width(input int unsigned offset_width);
    return WORD_WIDTH << offset_width;
  endfunction

endpackage

// File: rtl/l2_mem_line_ram.sv
// Single-port line store with per-byte write enables and a registered,
// write-first read so a committed write is visible on the following cycle.
module l2_mem_line_ram #(
  parameter int unsigned data_width  = 128,
  parameter int unsigned depth_width = 10
) (
  input  logic                    clk,
  input  logic [depth_width-1:0]  addr,
  input  logic [data_width/8-1:0] we,
  input  logic [data_width-1:0]   wdata,
  output logic [data_width-1:0]   q
);

  localparam int unsigned NUM_BYTES = data_width / 8;
  localparam int unsigned DEPTH     = 1 << depth_width;

  logic [data_width-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (we[b]) begin
        mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        q[b*8 +: 8]         <= wdata[b*8 +: 8];
      end else begin
        q[b*8 +: 8]         <= mem[addr][b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/l2_mem_responder.sv
// Fixed-latency memory model answering L2 line reads/writes, one transaction
// in flight, with write priority at accept and a shared dataOK handshake.
module l2_mem_responder
  import l2_mem_pkg::*;
#(
  parameter int unsigned offset_width    = DEFAULT_OFFSET_WIDTH,
  parameter int unsigned mem_index_width = DEFAULT_MEM_INDEX_WIDTH,
  parameter int unsigned latency         = DEFAULT_LATENCY
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [31:0]                           addr_l2cache_mem_r,
  input  logic [31:0]                           addr_l2cache_mem_w,
  input  logic [line_width(offset_width)-1:0]   dout_l2cache_mem,
  input  logic [WSTRB_WIDTH-1:0]                l2cache_mem_wstrb,
  input  logic                                  l2cache_mem_req_r,
  input  logic                                  l2cache_mem_req_w,
  input  logic                                  l2cache_mem_rdy,
  output logic [line_width(offset_width)-1:0]   din_mem_l2cache,
  output logic                                  mem_l2cache_addrOK_r,
  output logic                                  mem_l2cache_addrOK_w,
  output logic                                  mem_l2cache_dataOK
);

  localparam int unsigned LW        = line_width(offset_width);
  localparam int unsigned NUM_BYTES = LW / 8;
  localparam int unsigned IDX_LSB   = offset_width + 2;
  localparam bit          DIRECT    = (latency == 1);

  state_t                       state, state_next;
  logic [CNT_WIDTH-1:0]         cnt, cnt_next;
  logic                         is_write, is_write_next;
  logic [mem_index_width-1:0]   idx, idx_next;
  logic [LW-1:0]                wline, wline_next;
  logic [WSTRB_WIDTH-1:0]       wstrb, wstrb_next;

  logic                         commit;
  logic [mem_index_width-1:0]   ram_addr;
  logic [LW-1:0]                ram_wdata;
  logic [WSTRB_WIDTH-1:0]       commit_wstrb;
  logic [NUM_BYTES-1:0]         ram_we;
  logic [LW-1:0]                ram_q;
  logic                         unused_addr;

  // Offset, byte and aliasing upper address bits are intentionally ignored.
  assign unused_addr = ^{addr_l2cache_mem_r, addr_l2cache_mem_w};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      is_write <= 1'b0;
      idx      <= '0;
      wline    <= '0;
      wstrb    <= '0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      is_write <= is_write_next;
      idx      <= idx_next;
      wline    <= wline_next;
      wstrb    <= wstrb_next;
    end
  end

  always_comb begin
    state_next           = state;
    cnt_next             = cnt;
    is_write_next        = is_write;
    idx_next             = idx;
    wline_next           = wline;
    wstrb_next           = wstrb;
    mem_l2cache_addrOK_r = 1'b0;
    mem_l2cache_addrOK_w = 1'b0;
    commit               = 1'b0;
    ram_addr             = idx;
    ram_wdata            = wline;
    commit_wstrb         = wstrb;
    unique case (state)
      ST_IDLE: begin
        mem_l2cache_addrOK_w = l2cache_mem_req_w && !rst;
        mem_l2cache_addrOK_r = l2cache_mem_req_r && !l2cache_mem_req_w && !rst;
        if (l2cache_mem_req_w || l2cache_mem_req_r) begin
          is_write_next = l2cache_mem_req_w;
          idx_next      = l2cache_mem_req_w ?
                          addr_l2cache_mem_w[IDX_LSB +: mem_index_width] :
                          addr_l2cache_mem_r[IDX_LSB +: mem_index_width];
          wline_next    = l2cache_mem_req_w ? dout_l2cache_mem : '0;
          wstrb_next    = l2cache_mem_req_w ? l2cache_mem_wstrb : '0;
          // The RAM reads the new line on the accept edge itself.
          ram_addr      = idx_next;
          ram_wdata     = dout_l2cache_mem;
          commit_wstrb  = l2cache_mem_wstrb;
          if (DIRECT) begin
            state_next = ST_RESP;
            cnt_next   = '0;
            commit     = l2cache_mem_req_w;
          end else begin
            state_next = ST_WAIT;
            cnt_next   = CNT_WIDTH'(latency - 1);
          end
        end
      end
      ST_WAIT: begin
        cnt_next = cnt - CNT_WIDTH'(1);
        if (cnt == CNT_WIDTH'(1)) begin
          state_next = ST_RESP;
          commit     = is_write;
        end
      end
      ST_RESP: begin
        if (l2cache_mem_rdy) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Same byte mask applies to every word; reset suppresses a pending commit.
  always_comb begin
    ram_we = '0;
    for (int b = 0; b < NUM_BYTES; b++) begin
      ram_we[b] = commit && !rst && commit_wstrb[b % WSTRB_WIDTH];
    end
  end

  l2_mem_line_ram #(
    .data_width  (LW),
    .depth_width (mem_index_width)
  ) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

  assign mem_l2cache_dataOK = (state == ST_RESP);
  assign din_mem_l2cache    = (state == ST_RESP) ? ram_q : '0;

endmodule

// File: tb/tb_l2_mem_responder.sv
// Directed bench for l2_mem_responder: latency-4 instance plus a latency-1
// instance for the zero-wait boundary.
module tb_l2_mem_responder;

  localparam int unsigned LW = 128;

  localparam logic [LW-1:0] L1 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
  localparam logic [LW-1:0] LA = {4{32'hAAAAAAAA}};
  localparam logic [LW-1:0] LM = {32'h4444AAAA, 32'h3333AAAA, 32'h2222AAAA, 32'h1111AAAA};
  localparam logic [LW-1:0] LB = {4{32'hBBBBBBBB}};
  localparam logic [LW-1:0] L5 = {4{32'h55555555}};
  localparam logic [LW-1:0] LBA = {4{32'hAABBBBBB}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [31:0]   addr_r, addr_w;
  logic [LW-1:0] dout;
  logic [3:0]    wstrb;
  logic          req_r, req_w, rdy;
  logic [LW-1:0] din;
  logic          ok_r, ok_w, data_ok;

  logic [31:0]   addr_r1, addr_w1;
  logic [LW-1:0] dout1;
  logic [3:0]    wstrb1;
  logic          req_r1, req_w1, rdy1;
  logic [LW-1:0] din1;
  logic          ok_r1, ok_w1, data_ok1;

  int checks = 0;
  int errors = 0;

  l2_mem_responder #(.offset_width(2), .mem_index_width(10), .latency(4)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .addr_l2cache_mem_r   (addr_r),
    .addr_l2cache_mem_w   (addr_w),
    .dout_l2cache_mem     (dout),
    .l2cache_mem_wstrb    (wstrb),
    .l2cache_mem_req_r    (req_r),
    .l2cache_mem_req_w    (req_w),
    .l2cache_mem_rdy      (rdy),
    .din_mem_l2cache      (din),
    .mem_l2cache_addrOK_r (ok_r),
    .mem_l2cache_addrOK_w (ok_w),
    .mem_l2cache_dataOK   (data_ok)
  );

  l2_mem_responder #(.offset_width(2), .mem_index_width(10), .latency(1)) dut1 (
    .clk                  (clk),
    .rst                  (rst),
    .addr_l2cache_mem_r   (addr_r1),
    .addr_l2cache_mem_w   (addr_w1),
    .dout_l2cache_mem     (dout1),
    .l2cache_mem_wstrb    (wstrb1),
    .l2cache_mem_req_r    (req_r1),
    .l2cache_mem_req_w    (req_w1),
    .l2cache_mem_rdy      (rdy1),
    .din_mem_l2cache      (din1),
    .mem_l2cache_addrOK_r (ok_r1),
    .mem_l2cache_addrOK_w (ok_w1),
    .mem_l2cache_dataOK   (data_ok1)
  );

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write on the latency-4 instance with rdy=1; checks accept and dataOK timing.
  task automatic do_write(input logic [31:0] a, input logic [LW-1:0] d,
                          input logic [3:0] s, input string tag);
    addr_w = a; dout = d; wstrb = s; req_w = 1'b1; rdy = 1'b1;
    #1;
    chk({tag, "_okw"}, LW'(ok_w), LW'(1'b1));
    tick();
    req_w = 1'b0; dout = '0;
    for (int i = 1; i < 4; i++) begin
      chk({tag, "_wait_dok"}, LW'(data_ok), LW'(1'b0));
      tick();
    end
    chk({tag, "_t4_dok"}, LW'(data_ok), LW'(1'b1));
    tick();
    chk({tag, "_done_dok"}, LW'(data_ok), LW'(1'b0));
  endtask

  // Read on the latency-4 instance with rdy=1; checks timing and line data.
  task automatic do_read(input logic [31:0] a, input logic [LW-1:0] exp, input string tag);
    addr_r = a; req_r = 1'b1; rdy = 1'b1;
    #1;
    chk({tag, "_okr"}, LW'(ok_r), LW'(1'b1));
    tick();
    req_r = 1'b0;
    for (int i = 1; i < 4; i++) begin
      chk({tag, "_wait_dok"}, LW'(data_ok), LW'(1'b0));
      chk({tag, "_wait_din"}, din, '0);
      tick();
    end
    chk({tag, "_t4_dok"}, LW'(data_ok), LW'(1'b1));
    chk({tag, "_t4_din"}, din, exp);
    tick();
    chk({tag, "_done_din"}, din, '0);
  endtask

  initial begin
    rst = 1'b1;
    addr_r = '0; addr_w = '0; dout = '0; wstrb = '0; req_r = 1'b0; req_w = 1'b0; rdy = 1'b0;
    addr_r1 = '0; addr_w1 = '0; dout1 = '0; wstrb1 = '0; req_r1 = 1'b0; req_w1 = 1'b0; rdy1 = 1'b0;
    tick();
    tick();
    chk("rst_dok", LW'(data_ok), LW'(1'b0));
    chk("rst_din", din, '0);
    chk("rst_okr", LW'(ok_r), LW'(1'b0));
    chk("rst_okw", LW'(ok_w), LW'(1'b0));
    rst = 1'b0;

    // Preload, plain read, then partial-strobe merge and aliasing.
    do_write(32'h0000_0040, L1, 4'hF, "wr_l1");
    do_read(32'h0000_0040, L1, "rd_l1");
    do_write(32'h0000_0040, LA, 4'b0011, "wr_merge");
    do_read(32'h0000_0040, LM, "rd_merge");
    do_read(32'h0000_4040, LM, "rd_alias");

    // Simultaneous requests: write wins, read waits for completion.
    addr_w = 32'h0000_0080; dout = LB; wstrb = 4'hF; addr_r = 32'h0000_0040;
    req_w = 1'b1; req_r = 1'b1; rdy = 1'b1;
    #1;
    chk("both_okw", LW'(ok_w), LW'(1'b1));
    chk("both_okr", LW'(ok_r), LW'(1'b0));
    tick();
    req_w = 1'b0;
    for (int i = 1; i < 4; i++) begin
      chk("both_wait_okr", LW'(ok_r), LW'(1'b0));
      tick();
    end
    chk("both_resp_dok", LW'(data_ok), LW'(1'b1));
    chk("both_resp_okr", LW'(ok_r), LW'(1'b0));
    chk("both_resp_din", din, LB);
    tick();
    chk("both_idle_okr", LW'(ok_r), LW'(1'b1));
    tick();
    req_r = 1'b0;
    for (int i = 1; i < 4; i++) begin
      chk("both_rd_wait_dok", LW'(data_ok), LW'(1'b0));
      tick();
    end
    chk("both_rd_din", din, LM);
    tick();

    // Backpressure: rdy low for six RESP cycles, inputs wiggled in flight.
    addr_r = 32'h0000_0080; req_r = 1'b1; rdy = 1'b0;
    #1;
    chk("bp_okr", LW'(ok_r), LW'(1'b1));
    tick();
    req_r = 1'b0; addr_r = 32'h0000_0040;
    addr_w = 32'h0000_0080; dout = L5; wstrb = 4'hF; req_w = 1'b1;
    tick();
    tick();
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("bp_dok", LW'(data_ok), LW'(1'b1));
      chk("bp_din", din, LB);
      chk("bp_okw", LW'(ok_w), LW'(1'b0));
      if (i == 5) begin
        req_w = 1'b0;
        rdy = 1'b1;
      end
      tick();
    end
    chk("bp_after_dok", LW'(data_ok), LW'(1'b0));
    req_r = 1'b1;
    #1;
    chk("bp_idle_okr", LW'(ok_r), LW'(1'b1));
    req_r = 1'b0;
    tick();
    do_read(32'h0000_0080, LB, "rd_after_bp");

    // Reset in the last WAIT cycle of a write: nothing is committed.
    addr_w = 32'h0000_0040; dout = L5; wstrb = 4'hF; req_w = 1'b1; rdy = 1'b1;
    #1;
    chk("abort_okw", LW'(ok_w), LW'(1'b1));
    tick();
    req_w = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("abort_dok", LW'(data_ok), LW'(1'b0));
    chk("abort_din", din, '0);
    rst = 1'b0;
    tick();
    do_read(32'h0000_0040, LM, "rd_after_abort");

    // Latency 1: dataOK the cycle after accept, post-commit data for writes.
    addr_w1 = 32'h0000_0100; dout1 = LB; wstrb1 = 4'hF; req_w1 = 1'b1; rdy1 = 1'b1;
    #1;
    chk("l1_wr_okw", LW'(ok_w1), LW'(1'b1));
    tick();
    req_w1 = 1'b0;
    chk("l1_wr_dok", LW'(data_ok1), LW'(1'b1));
    chk("l1_wr_din", din1, LB);
    tick();
    chk("l1_wr_done", LW'(data_ok1), LW'(1'b0));
    addr_w1 = 32'h0000_0100; dout1 = LA; wstrb1 = 4'b1000; req_w1 = 1'b1;
    tick();
    req_w1 = 1'b0;
    chk("l1_merge_din", din1, LBA);
    tick();
    addr_r1 = 32'h0000_0100; req_r1 = 1'b1; rdy1 = 1'b0;
    #1;
    chk("l1_rd_okr", LW'(ok_r1), LW'(1'b1));
    tick();
    req_r1 = 1'b0;
    chk("l1_rd_dok", LW'(data_ok1), LW'(1'b1));
    chk("l1_rd_din", din1, LBA);
    tick();
    chk("l1_rd_hold", din1, LBA);
    rdy1 = 1'b1;
    tick();
    chk("l1_rd_done", LW'(data_ok1), LW'(1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
